pong_game_ctrl: RTL and testbench

Match-level sequencer for the Pong datapath. Holds the ball centred between points, releases it on serve, converts ball-miss events from the collision logic into per-player scores, and ends the match at a configurable winning score. Sits between the player input/collision logic and the ball module; drives the ball's hold/recentre control and serve direction, and feeds scores to the score display.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_game_ctrl_sync_edge_det.sv | 28 ++
 rtl/pong_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and constants: FSM state encoding, winner codes, default
// winning score, screen geometry and small helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEFAULT_WIN_SCORE = 7;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Scores stop at the winning score, so the 4-bit register can never wrap.
  function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_sync_edge_det.sv
// Two-flop synchroniser followed by a registered edge detector; RISE selects
// rising (1) or falling (0) edge. The pulse lands 3 clk after the input edge.
module sync_edge_det #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s0, s1, s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s0    <= din;
      s1    <= s0;
      s2    <= s1;
      pulse <= RISE ? (s1 & ~s2) : (~s1 & s2);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve hold, miss-to-score conversion, match end.
// Build option PONG_AUTO_SERVE_EN: serve automatically once the serve delay expires.
//
// state         | meaning
// ST_IDLE       | power-up, ball held, waiting for first serve press
// ST_SERVE_WAIT | ball centred, counting frames until serve is allowed
// ST_PLAY       | ball moving, misses sampled on frame ticks
// ST_POINT      | ball frozen for the post-point pause
// ST_GAME_OVER  | winner shown, scores frozen until next serve press
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = DEFAULT_WIN_SCORE,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       serve_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] game_state
);

  localparam int CNT_W = $clog2(max_int(SERVE_DELAY_FRAMES, POINT_PAUSE_FRAMES) + 1);
  localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [CNT_W-1:0] PAUSE_CNT = CNT_W'(POINT_PAUSE_FRAMES);
  localparam logic [3:0]       WIN4      = 4'(WIN_SCORE);

  logic             frame_tick;
  logic             serve_evt;
  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt_adv;
  logic             serve_go;

  sync_edge_det #(.RISE(1'b0)) u_vsync_det (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .pulse (frame_tick)
  );

  sync_edge_det #(.RISE(1'b1)) u_serve_det (
    .clk   (clk),
    .reset (reset),
    .din   (serve_btn),
    .pulse (serve_evt)
  );

  // Counter saturates at the current state's target so a manual serve can wait forever.
  always_comb begin
    cnt_limit = (state == ST_POINT) ? PAUSE_CNT : SERVE_CNT;
    cnt_adv   = frame_cnt;
    if (frame_tick && (frame_cnt < cnt_limit))
      cnt_adv = frame_cnt + CNT_W'(1);
`ifdef PONG_AUTO_SERVE_EN
    serve_go = frame_tick && (cnt_adv == SERVE_CNT);
`else
    serve_go = serve_evt && (cnt_adv == SERVE_CNT);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      game_state <= ST_IDLE;
      frame_cnt  <= '0;
      ball_hold  <= 1'b1;
      serve_dir  <= 1'b1;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      winner     <= WIN_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (serve_evt) begin
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            winner     <= WIN_NONE;
            serve_dir  <= 1'b1;
            frame_cnt  <= '0;
            ball_hold  <= 1'b1;
            state      <= ST_SERVE_WAIT;
            game_state <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          frame_cnt <= cnt_adv;
          if (serve_go) begin
            frame_cnt  <= '0;
            ball_hold  <= 1'b0;
            state      <= ST_PLAY;
            game_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (frame_tick && (miss_left || miss_right)) begin
            if (miss_left) begin
              score_p2  <= score_inc(score_p2, WIN4);
              serve_dir <= 1'b0;
            end else begin
              score_p1  <= score_inc(score_p1, WIN4);
              serve_dir <= 1'b1;
            end
            frame_cnt  <= '0;
            ball_hold  <= 1'b1;
            state      <= ST_POINT;
            game_state <= ST_POINT;
          end
        end
        ST_POINT: begin
          frame_cnt <= cnt_adv;
          if (cnt_adv == PAUSE_CNT) begin
            frame_cnt <= '0;
            ball_hold <= 1'b1;
            if (score_p1 == WIN4) begin
              winner     <= WIN_P1;
              state      <= ST_GAME_OVER;
              game_state <= ST_GAME_OVER;
            end else if (score_p2 == WIN4) begin
              winner     <= WIN_P2;
              state      <= ST_GAME_OVER;
              game_state <= ST_GAME_OVER;
            end else begin
              state      <= ST_SERVE_WAIT;
              game_state <= ST_SERVE_WAIT;
            end
          end
        end
        default: begin
          frame_cnt  <= '0;
          ball_hold  <= 1'b1;
          state      <= ST_IDLE;
          game_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: expected snapshots are queued as stimulus
// is applied and popped/compared once the DUT has had time to respond.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset, vsync, serve_btn, miss_left, miss_right;
  logic       ball_hold, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] game_state;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .serve_btn  (serve_btn),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_hold  (ball_hold),
    .serve_dir  (serve_dir),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .winner     (winner),
    .game_state (game_state)
  );

  typedef struct {
    string      tag;
    state_t     st;
    logic       hold;
    logic       dir;
    int         s1;
    int         s2;
    logic [1:0] win;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_s1 = 0;
  int   exp_s2 = 0;
  logic exp_dir = 1'b1;
  int   lat;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input state_t st, input logic hold,
                          input logic dir, input int s1, input int s2, input logic [1:0] win);
    exp_t e;
    e.tag = tag; e.st = st; e.hold = hold; e.dir = dir;
    e.s1 = s1; e.s2 = s2; e.win = win;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".state"},  int'(game_state), int'(e.st));
      check_val({e.tag, ".hold"},   int'(ball_hold),  int'(e.hold));
      check_val({e.tag, ".dir"},    int'(serve_dir),  int'(e.dir));
      check_val({e.tag, ".p1"},     int'(score_p1),   e.s1);
      check_val({e.tag, ".p2"},     int'(score_p2),   e.s2);
      check_val({e.tag, ".winner"}, int'(winner),     int'(e.win));
    end
  endtask

  // One vsync period: 4 clk low, 4 clk high; state reacts during the low phase.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (4) @(posedge clk);
    end
  endtask

  // Frame with misses held; lat = clk edges from vsync fall until ball_hold is 1.
  task automatic miss_frame(input logic l, input logic r, output int lat_o);
    miss_left = l; miss_right = r;
    @(posedge clk); #1 vsync = 1'b0;
    lat_o = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ball_hold === 1'b1 && lat_o == 99) lat_o = i;
    end
    vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1 miss_left = 1'b0; miss_right = 1'b0;
  endtask

  // Serve press; lat = clk edges from button rise until game_state changes (99 = none).
  task automatic press(output int lat_o);
    logic [2:0] st0;
    @(posedge clk); #1;
    st0 = game_state;
    serve_btn = 1'b1;
    lat_o = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (game_state !== st0 && lat_o == 99) lat_o = i;
    end
    serve_btn = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic serve_from_wait();
    int l;
`ifdef PONG_AUTO_SERVE_EN
    frames(59);
    push_exp("auto_pre", ST_SERVE_WAIT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();
    frames(1);
`else
    frames(60);
    press(l);
`endif
    push_exp("serve", ST_PLAY, 1'b0, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; vsync = 1'b1; serve_btn = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (3) @(posedge clk);
    push_exp("reset", ST_IDLE, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);

    press(lat);
    check_val("idle_serve_lat", lat, 4);
    push_exp("idle_serve", ST_SERVE_WAIT, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();

`ifdef PONG_AUTO_SERVE_EN
    serve_from_wait();
`else
    frames(30);
    press(lat);
    check_val("early_serve_lat", lat, 99);
    push_exp("early_serve", ST_SERVE_WAIT, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();
    frames(31);
    press(lat);
    check_val("late_serve_lat", lat, 4);
    push_exp("late_serve", ST_PLAY, 1'b0, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();
`endif

    press(lat);
    push_exp("play_press", ST_PLAY, 1'b0, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();

    miss_frame(1'b0, 1'b1, lat);
    check_val("miss_lat", lat, 4);
    exp_s1 = 1; exp_dir = 1'b1;
    push_exp("miss_right", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();

    press(lat);
    push_exp("point_press", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();
    frames(89);
    push_exp("pause_89", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();
    frames(1);
    push_exp("pause_90", ST_SERVE_WAIT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();

    serve_from_wait();
    miss_frame(1'b1, 1'b1, lat);
    exp_s2 = 1; exp_dir = 1'b0;
    push_exp("miss_both", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
    pop_cmp();

    for (int i = 0; i < 6; i++) begin
      frames(90);
      push_exp("p2_wait", ST_SERVE_WAIT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
      pop_cmp();
      serve_from_wait();
      miss_frame(1'b1, 1'b0, lat);
      exp_s2++;
      push_exp("p2_point", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
      pop_cmp();
    end

    frames(90);
    push_exp("game_over", ST_GAME_OVER, 1'b1, exp_dir, 1, 7, WIN_P2);
    pop_cmp();
    miss_frame(1'b1, 1'b0, lat);
    miss_frame(1'b0, 1'b1, lat);
    push_exp("frozen", ST_GAME_OVER, 1'b1, exp_dir, 1, 7, WIN_P2);
    pop_cmp();

    press(lat);
    exp_s1 = 0; exp_s2 = 0; exp_dir = 1'b1;
    push_exp("rematch", ST_SERVE_WAIT, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();

    for (int i = 0; i < 8; i++) begin
      serve_from_wait();
      if (i < 5) begin
        miss_frame(1'b1, 1'b0, lat);
        exp_s2++; exp_dir = 1'b0;
      end else begin
        miss_frame(1'b0, 1'b1, lat);
        exp_s1++; exp_dir = 1'b1;
      end
      push_exp("build", ST_POINT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
      pop_cmp();
      if (i < 7) begin
        frames(90);
        push_exp("build_wait", ST_SERVE_WAIT, 1'b1, exp_dir, exp_s1, exp_s2, WIN_NONE);
        pop_cmp();
      end
    end

    frames(10);
    @(posedge clk); #2 reset = 1'b0;
    push_exp("mid_reset", ST_IDLE, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    push_exp("post_reset", ST_IDLE, 1'b1, 1'b1, 0, 0, WIN_NONE);
    pop_cmp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
